// File: rtl/bht_update_queue.sv
// -----------------------------------------------------------------------------
// bht_update_queue
//   Tracks conditional branches predicted through the 2-bit BHT from fetch until
//   they resolve in execute. Flags mispredictions (squashing younger wrong-path
//   entries) and drains resolved outcomes in program order to the BHT write port.
//
// Parameters
//   DEPTH  in-flight entries (power of two, >= 2)
//   PTR_W  entry tag width
//
// Ports
//   clk, rstn                      clock, async active-low reset
//   i_alloc_*  / o_alloc_ready/tag  fetch-side allocation (tag = tail index)
//   i_resolve_*                    branch-unit resolution by tag
//   o_mispredict / o_mispredict_tag registered one-cycle mispredict pulse
//   i_flush                        discard all entries (highest priority)
//   o_bht_write_*                  registered BHT update strobe, one per entry
//   o_count                        live entries
//   o_stat_resolved / o_stat_mispred  event counters
//
// Build option
//   BHT_UPD_STATS_EN  enables the two 32-bit statistics counters; when not
//                     defined both ports read 0 and no counter flops exist.
// -----------------------------------------------------------------------------
module bht_update_queue #(
   parameter int DEPTH = 8,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_alloc_valid,
   input  logic [31:0]      i_alloc_pc,
   input  logic             i_alloc_pred_taken,
   input  logic             i_alloc_hit,
   output logic             o_alloc_ready,
   output logic [PTR_W-1:0] o_alloc_tag,
   input  logic             i_resolve_valid,
   input  logic [PTR_W-1:0] i_resolve_tag,
   input  logic             i_resolve_taken,
   output logic             o_mispredict,
   output logic [PTR_W-1:0] o_mispredict_tag,
   input  logic             i_flush,
   output logic             o_bht_write_en,
   output logic [31:0]      o_bht_write_pc,
   output logic             o_bht_write_taken,
   output logic [PTR_W:0]   o_count,
   output logic [31:0]      o_stat_resolved,
   output logic [31:0]      o_stat_mispred
);

   localparam int CW = PTR_W + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [CW-1:0]               head_q, head_d, tail_q, tail_d;
   logic [DEPTH-1:0]            valid_q, valid_d, resolved_q, resolved_d;
   logic [DEPTH-1:0]            pred_q, pred_d, hit_q, hit_d, actual_q, actual_d;
   logic [DEPTH-1:0][31:0]      pc_q, pc_d;
   logic                        wr_en_q, wr_en_d, wr_taken_q, wr_taken_d;
   logic [31:0]                 wr_pc_q, wr_pc_d;
   logic                        mis_q, mis_d;
   logic [PTR_W-1:0]            mis_tag_q, mis_tag_d;

   logic [CW-1:0]    count;
   logic [PTR_W-1:0] head_idx, tail_idx, res_off, ent_off;
   logic             alloc_ready, res_ok, res_mis, drain;

   // Hit is kept with the entry for visibility only; it never gates the write.
   logic unused_hit;
   assign unused_hit = ^hit_q;

   assign count       = tail_q - head_q;
   assign head_idx    = head_q[PTR_W-1:0];
   assign tail_idx    = tail_q[PTR_W-1:0];
   assign alloc_ready = (count < DEPTH_C);

   // Position of the resolving tag relative to head; in [head, tail) iff < count.
   assign res_off = i_resolve_tag - head_idx;
   assign res_ok  = i_resolve_valid && ({1'b0, res_off} < count) &&
                    valid_q[i_resolve_tag] && !resolved_q[i_resolve_tag];
   assign res_mis = res_ok && (i_resolve_taken != pred_q[i_resolve_tag]);
   // Uses the registered resolved bit, so a resolve drains no earlier than next cycle.
   assign drain   = (count != '0) && valid_q[head_idx] && resolved_q[head_idx];

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      valid_d    = valid_q;
      resolved_d = resolved_q;
      pred_d     = pred_q;
      hit_d      = hit_q;
      actual_d   = actual_q;
      pc_d       = pc_q;
      wr_en_d    = 1'b0;
      wr_pc_d    = wr_pc_q;
      wr_taken_d = wr_taken_q;
      mis_d      = 1'b0;
      mis_tag_d  = mis_tag_q;
      ent_off    = '0;

      if (i_flush) begin
         head_d  = '0;
         tail_d  = '0;
         valid_d = '0;
      end else begin
         if (drain) begin
            wr_en_d           = 1'b1;
            wr_pc_d           = pc_q[head_idx];
            wr_taken_d        = actual_q[head_idx];
            valid_d[head_idx] = 1'b0;
            head_d            = head_q + CW'(1);
         end

         if (res_ok) begin
            resolved_d[i_resolve_tag] = 1'b1;
            actual_d[i_resolve_tag]   = i_resolve_taken;
         end

         if (res_mis) begin
            mis_d     = 1'b1;
            mis_tag_d = i_resolve_tag;
            // Computed from the full-width head so the wrap bit stays consistent.
            tail_d    = head_q + {1'b0, res_off} + CW'(1);
            for (int i = 0; i < DEPTH; i++) begin
               ent_off = PTR_W'(i) - head_idx;
               if (ent_off > res_off) valid_d[i] = 1'b0;
            end
         end else if (i_alloc_valid && alloc_ready) begin
            // A same-cycle allocation is on the wrong path when a squash happens.
            valid_d[tail_idx]    = 1'b1;
            resolved_d[tail_idx] = 1'b0;
            pred_d[tail_idx]     = i_alloc_pred_taken;
            hit_d[tail_idx]      = i_alloc_hit;
            actual_d[tail_idx]   = 1'b0;
            pc_d[tail_idx]       = i_alloc_pc;
            tail_d               = tail_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         head_q     <= '0;
         tail_q     <= '0;
         valid_q    <= '0;
         resolved_q <= '0;
         pred_q     <= '0;
         hit_q      <= '0;
         actual_q   <= '0;
         pc_q       <= '0;
         wr_en_q    <= 1'b0;
         wr_pc_q    <= '0;
         wr_taken_q <= 1'b0;
         mis_q      <= 1'b0;
         mis_tag_q  <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         valid_q    <= valid_d;
         resolved_q <= resolved_d;
         pred_q     <= pred_d;
         hit_q      <= hit_d;
         actual_q   <= actual_d;
         pc_q       <= pc_d;
         wr_en_q    <= wr_en_d;
         wr_pc_q    <= wr_pc_d;
         wr_taken_q <= wr_taken_d;
         mis_q      <= mis_d;
         mis_tag_q  <= mis_tag_d;
      end
   end

   assign o_alloc_ready     = alloc_ready;
   assign o_alloc_tag       = tail_idx;
   assign o_mispredict      = mis_q;
   assign o_mispredict_tag  = mis_tag_q;
   assign o_bht_write_en    = wr_en_q;
   assign o_bht_write_pc    = wr_pc_q;
   assign o_bht_write_taken = wr_taken_q;
   assign o_count           = count;

`ifdef BHT_UPD_STATS_EN
   logic [31:0] stat_res_q, stat_res_d, stat_mis_q, stat_mis_d;

   // Flush drops the concurrent resolve, so it is not counted.
   always_comb begin
      stat_res_d = stat_res_q;
      stat_mis_d = stat_mis_q;
      if (!i_flush && res_ok)  stat_res_d = stat_res_q + 32'd1;
      if (!i_flush && res_mis) stat_mis_d = stat_mis_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stat_res_q <= '0;
         stat_mis_q <= '0;
      end else begin
         stat_res_q <= stat_res_d;
         stat_mis_q <= stat_mis_d;
      end
   end

   assign o_stat_resolved = stat_res_q;
   assign o_stat_mispred  = stat_mis_q;
`else
   assign o_stat_resolved = '0;
   assign o_stat_mispred  = '0;
`endif

endmodule

// File: doc/bht_update_queue.md
# bht_update_queue

Tracks every conditional branch that the fetch stage predicts through the 2-bit BHT until the branch resolves in execute. It flags mispredictions and squashes younger wrong-path entries. It then drains resolved outcomes in program order to the BHT write port (write_en / write_pc / write_taken). It sits between fetch, the branch unit and the BHT, and is the producer side of the BHT update interface.

## Interface
- DEPTH, 8: number of in-flight branch entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH): width of the entry tag.
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- i_alloc_valid  in  1  fetch presents a predicted branch
- i_alloc_pc  in  32  branch PC
- i_alloc_pred_taken  in  1  prediction used by fetch
- i_alloc_hit  in  1  BHT hit flag returned with the prediction
- o_alloc_ready  out  1  queue can accept an allocation (combinational, count < DEPTH)
- o_alloc_tag  out  PTR_W  tag given to this cycle's allocation (tail index, combinational)
- i_resolve_valid  in  1  branch unit resolves one entry
- i_resolve_tag  in  PTR_W  tag being resolved
- i_resolve_taken  in  1  actual outcome
- o_mispredict  out  1  registered one-cycle pulse on a wrong prediction
- o_mispredict_tag  out  PTR_W  tag of the mispredicted entry
- i_flush  in  1  pipeline flush; discards all entries
- o_bht_write_en  out  1  BHT update strobe
- o_bht_write_pc  out  32  PC to update
- o_bht_write_taken  out  1  actual outcome to train
- o_count  out  PTR_W+1  live entries
- o_stat_resolved  out  32  resolved-branch counter (see Configuration)
- o_stat_mispred  out  32  mispredict counter (see Configuration)

## Operation
- Circular buffer with head/tail pointers of PTR_W+1 bits; the extra bit disambiguates full from empty. Each entry holds {valid, resolved, pc, pred_taken, hit, actual}.
- Allocate: when i_alloc_valid && o_alloc_ready, write the entry at the tail with valid=1 and resolved=0, and increment the tail.
- Resolve: a resolve is accepted only if the tag lies in [head, tail), valid=1 and resolved=0; otherwise it is silently ignored.
  - An accepted resolve sets resolved=1 and stores actual.
  - If actual != pred_taken: o_mispredict=1 and o_mispredict_tag=tag on the next cycle. In the same edge, tail is set to tag+1 (same wrap bit as tag's position relative to head) and all younger entries are invalidated.
- Drain: if the head entry has resolved=1 (set in a prior cycle), issue a BHT write {pc, actual} and advance the head. At most one drain per cycle.
  - Mispredicted entries are drained normally, so they train with the actual outcome.
  - The hit flag does not gate the write.
- The queue has no FSM; the state is the pointers plus per-entry bits. o_count = tail - head, modulo 2^(PTR_W+1).

## Timing
- Reset values: o_bht_write_en=0, o_bht_write_pc=0, o_bht_write_taken=0, o_mispredict=0, o_mispredict_tag=0, o_count=0, head=tail=0, all valid=0, stats=0. After reset o_alloc_ready=1 and o_alloc_tag=0.
- Allocate to resolve-eligible: next cycle.
- Resolve to write: earliest o_bht_write_en is 2 cycles after the resolve edge (resolved bit set, then head drain registered).
- The BHT write outputs are registered and assert for exactly one cycle per entry. At most one write is issued per cycle.
- Full: o_alloc_ready=0, and i_alloc_valid is ignored. A drain in the same cycle does not raise ready combinationally.
- Alloc in the same cycle as a mispredicting resolve: the allocation is discarded (wrong path) and the tail follows the squash.
- Drain in the same cycle as a squash: both take effect, and the count reflects both.
- i_flush: highest priority. head=tail=0, all valid cleared, no write and no mispredict issued the next cycle. Simultaneous alloc and resolve are dropped.
- rstn asserted mid-drain: outputs clear immediately (asynchronous). No partial write is held.

## Configuration
- BHT_UPD_STATS_EN defined: o_stat_resolved increments on each accepted resolve, and o_stat_mispred on each mispredict. Both are 32-bit wrapping counters, cleared by reset and not by flush.
- BHT_UPD_STATS_EN undefined: both ports are tied to 0 and no counter flops exist.

## Test plan
- Alloc PC 0x1234 with pred=1, resolve tag 0 taken=1 -> no mispredict. Two cycles later write_en=1, pc=0x1234, taken=1, and count returns to 0.
- Fill 8 entries -> o_alloc_ready=0 and a 9th alloc is ignored. Resolve tag 0 -> after the drain, ready=1 and o_alloc_tag=0 (wrapped).
- Alloc tags 0..3, resolve tag 1 with mispredict -> o_mispredict=1 with tag 1 for one cycle, and count=2. A later resolve of tag 3 is ignored. The writes issued are for tags 0 and 1 only.
- Resolve tags out of order (2, then 0, then 1) -> writes are issued in order 0, 1, 2, each one cycle apart.
- i_flush with 5 live entries plus a concurrent resolve -> count=0, and no write or mispredict follows.
- With BHT_UPD_STATS_EN: 4 resolves including 1 mispredict -> o_stat_resolved=4 and o_stat_mispred=1. Without the macro both read 0.
